// File: rtl/seg7_scan_decoder.sv
// Recovers BCD digits and whole frames from a time-multiplexed, active-low 7-segment bus.
// Latency: digit pulse STABLE_CYCLES+1 edges after the bus settles; frame pulse one cycle after its last digit.
// No backpressure: the bus is observed passively and every output pulse must be taken when it appears.
module seg7_scan_decoder #(
  parameter  int NUM_DIGITS    = 6,
  parameter  int STABLE_CYCLES = 4,
  parameter  int CNT_W         = 8,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [3:0]              digit_out,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    digit_valid,
  output logic                    digit_err,
  output logic [4*NUM_DIGITS-1:0] frame_bcd,
  output logic                    frame_valid,
  output logic                    frame_err
);

  typedef struct packed {
    logic [6:0]            seg;
    logic [NUM_DIGITS-1:0] sel;
  } sample_t;

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Returns {err, bcd}; unknown patterns decode to F with err set.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40:   return 5'h00;
      7'h79:   return 5'h01;
      7'h24:   return 5'h02;
      7'h30:   return 5'h03;
      7'h19:   return 5'h04;
      7'h12:   return 5'h05;
      7'h02:   return 5'h06;
      7'h78:   return 5'h07;
      7'h00:   return 5'h08;
      7'h10:   return 5'h09;
      default: return 5'h1F;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] onehot_index(input logic [NUM_DIGITS-1:0] sel);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  sample_t                 smp;
  sample_t                 smp_prev;
  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   mask_next;
  logic                    sticky_err;
  logic                    sticky_next;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic                    sel_onehot;
  logic                    changed;
  logic                    capture;
  logic                    frame_done;
  logic [3:0]              dec_val;
  logic                    dec_err;
  logic [IDX_W-1:0]        cap_idx;

  assign sel_onehot = (|smp.sel) && ((smp.sel & (smp.sel - NUM_DIGITS'(1))) == '0);
  assign changed    = (smp != smp_prev);
  assign capture    = (state == SETTLE) && sel_onehot && !changed && (cnt == CNT_LAST);
  assign {dec_err, dec_val} = decode_seg(smp.seg);
  assign cap_idx    = onehot_index(smp.sel);

  // A capture landing on the frame-completion edge seeds the next frame.
  assign frame_done  = &mask;
  assign mask_next   = (frame_done ? '0 : mask) | (capture ? smp.sel : '0);
  assign sticky_next = (sticky_err & !frame_done) | (capture & dec_err);

  always_ff @(posedge clk) begin
    if (reset) begin
      smp         <= '0;
      smp_prev    <= '0;
      state       <= IDLE;
      cnt         <= '0;
      digit_out   <= '0;
      digit_idx   <= '0;
      digit_valid <= 1'b0;
      digit_err   <= 1'b0;
    end else begin
      smp         <= '{seg: seg_in, sel: dig_sel};
      smp_prev    <= smp;
      digit_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (sel_onehot) state <= SETTLE;
        end
        SETTLE: begin
          if (!sel_onehot) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (changed) begin
            cnt <= '0;
          end else begin
            if (cnt < CNT_MAX) cnt <= cnt + CNT_W'(1);
            if (capture) begin
              state       <= HOLD;
              digit_valid <= 1'b1;
              digit_out   <= dec_val;
              digit_idx   <= cap_idx;
              digit_err   <= dec_err;
            end
          end
        end
        HOLD: begin
          if (!sel_onehot) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (changed) begin
            state <= SETTLE;
            cnt   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask        <= '0;
      sticky_err  <= 1'b0;
      shadow      <= '0;
      frame_bcd   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (frame_done) begin
        frame_bcd   <= shadow;
        frame_valid <= 1'b1;
        frame_err   <= sticky_err;
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && smp.sel[i]) shadow[4*i +: 4] <= dec_val;
      end
      mask       <= mask_next;
      sticky_err <= sticky_next;
    end
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart to the team's BCD-to-7-segment encoder: watches a time-multiplexed, active-low 7-segment bus and recovers BCD digits.
- Debounces each digit dwell, decodes the segment pattern to BCD and assembles a full multi-digit frame.
- Used as a loopback monitor on the DE-10 Standard display path, and to check display drivers in synth-level benches.

Parameters:
- NUM_DIGITS, 6, number of multiplexed digit positions on the bus.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (legal range ≥1).
- CNT_W, 8, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- seg_in  input  7  active-low segment pattern, bit0=a … bit6=g
- dig_sel  input  NUM_DIGITS  one-hot, active-high digit enable
- digit_out  output  4  decoded BCD of last captured digit; 4'hF on error
- digit_idx  output  clog2(NUM_DIGITS)  position of last captured digit
- digit_valid  output  1  one-cycle pulse: digit_out/digit_idx/digit_err are new
- digit_err  output  1  last capture was not a legal pattern
- frame_bcd  output  4*NUM_DIGITS  assembled frame; digit i at bits [4i+3:4i]
- frame_valid  output  1  one-cycle pulse: frame_bcd updated
- frame_err  output  1  at least one digit in the last frame was invalid

Behaviour:
- Reset values: every output 0, frame_bcd 0, internal capture mask 0, state IDLE, counter 0.
- Input stage: {seg_in, dig_sel} registered once per clk. The stability compare runs on this registered copy against its previous value.
- Decode table, seg → BCD:
  - 7'h40→0, 7'h79→1, 7'h24→2, 7'h30→3, 7'h19→4
  - 7'h12→5, 7'h02→6, 7'h78→7, 7'h00→8, 7'h10→9
  - Any other pattern → 4'hF with digit_err=1.
- State machine:
  - IDLE: registered dig_sel not exactly one-hot (zero or multiple bits set). Counter held 0, no capture. Go to SETTLE when dig_sel becomes one-hot.
  - SETTLE: counter increments while the sample equals the previous sample. Any change in seg or dig_sel resets the counter to 0 and stays in SETTLE; a non-one-hot dig_sel goes to IDLE. When the same value has been present for STABLE_CYCLES consecutive samples, capture and go to HOLD.
  - HOLD: exactly one capture per dwell. Any change returns to SETTLE with counter 0, or to IDLE if dig_sel is not one-hot. Counter does not run.
- Latency: inputs changed and then held from edge k → digit_valid high during the cycle after edge k+STABLE_CYCLES+1, for exactly one cycle. digit_out, digit_idx and digit_err update in the same cycle and hold until the next capture.
- Frame assembly:
  - On capture, the decoded value is written to shadow slot digit_idx and that mask bit is set.
  - Recapturing a slot before the frame completes overwrites the slot.
  - An error capture sets a sticky frame-error flag.
  - Once all NUM_DIGITS mask bits are set, in the cycle after the completing digit_valid: frame_bcd ← shadow, frame_valid pulses 1 cycle, frame_err ← sticky flag. Then mask and sticky flag clear.
  - frame_bcd and frame_err hold between frames.
- Simultaneous events: a capture in the same cycle the mask clears is counted toward the new frame, not lost.
- Counter saturates at STABLE_CYCLES; no wrap.
- Reset mid-dwell or mid-frame: all state discarded. The partial frame is never emitted.

Test Plan:
1. STABLE_CYCLES=4; dig_sel=6'b000001, seg_in=7'h24 held 10 cycles → exactly one digit_valid, 5 edges after apply; digit_out=2, digit_idx=0, digit_err=0.
2. Glitch: seg_in=7'h30 for 2 cycles, then 7'h19 held → no capture for 7'h30; single capture digit_out=4 timed from the 7'h19 change.
3. Full scan: digits 0..5 fed 7'h79, 7'h40, 7'h78, 7'h02, 7'h00, 7'h10, 6 cycles each → frame_valid once; frame_bcd=24'h986701; frame_err=0.
4. Bad pattern: slot 3 fed 7'h7F during a scan → digit_out=F and digit_err=1 at that capture; frame_bcd slot 3=F; frame_err=1. Next clean scan → frame_err=0.
5. dig_sel=6'b000011 or 6'b000000 held 20 cycles → no digit_valid, state IDLE.
6. Reset asserted after 3 of 6 digits captured, then a full clean scan → frame_valid only after all 6 new captures; no stale slots carried over.
